pcs_receive: RTL
================

# pcs_receive

1000BASE-X PCS receive stage: consumes the aligned code-group stream (`SUDI`) produced by the synchronization block and reconstructs GMII receive signals. It performs 8b/10b decoding, runs the receive state machine (idle tracking, start/end-of-packet delimiting, error signalling), and drives `RXD`/`RX_DV`/`RX_ER`. It sits directly downstream of the sync block, closing the transmit → sync → receive loopback path.

## Interface
- No parameters.
- `Clk` input 1: single clock, all state updates on the rising edge.
- `mr_main_reset` input 1: reset, synchronous, active-high.
- `code_sync_status` input 1: 1 = sync block has acquired code-group alignment.
- `SUDI_indicate` input 1: 1 = `SUDI` carries a new code group this cycle.
- `SUDI` input 11: `[10]` = rx_even; `[9:0]` = code group, bit order abcdei fghj with a at bit 9.
- `RXD` output 8: decoded data octet.
- `RX_DV` output 1: receive data valid.
- `RX_ER` output 1: receive error.
- `receiving` output 1: 1 while a packet is in progress (START_OF_PACKET through end delimiter).

## Operation
- Decoder: full 8b/10b Dx.y table in both disparity columns, plus the K28.5 (/K/), K27.7 (/S/), K29.7 (/T/) and K23.7 (/R/) special groups. Any other 10-bit pattern is INVALID.
- Running disparity (RD) register: reset to RD−. After each accepted group, RD is set as follows: 6 ones → RD+, 4 ones → RD−, 5 ones → unchanged.
- The state advances only on cycles with `SUDI_indicate`=1. With `SUDI_indicate`=0, all state and outputs hold.
- If `code_sync_status`=0, the FSM enters LINK_FAILED from any state, regardless of `SUDI_indicate`.
- States and transitions (each transition consumes one indicated group):
  - LINK_FAILED: `RX_DV`=0, `RXD`=0x00. Sets `RX_ER`=1 for one cycle if entered from START_OF_PACKET/RECEIVE; otherwise `RX_ER`=0. Moves to WAIT_FOR_K when `code_sync_status`=1.
  - WAIT_FOR_K: moves to RX_K on /K/ with rx_even=1. Otherwise stays.
  - RX_K: moves to IDLE_D on a valid D group. Otherwise moves to WAIT_FOR_K.
  - IDLE_D: /K/ → RX_K. /S/ → START_OF_PACKET. Anything else → WAIT_FOR_K.
  - START_OF_PACKET: `RX_DV`=1, `RXD`=0x55, `receiving`=1. The next group is processed as in RECEIVE.
  - RECEIVE, by next group:
    - Valid D → `RXD`=decoded octet, `RX_DV`=1, `RX_ER`=0.
    - INVALID → `RX_DV`=1, `RX_ER`=1, `RXD` holds; stays in RECEIVE.
    - /T/ → TRI_RRI.
    - /K/ → EARLY_END.
  - EARLY_END: `RX_DV`=0, `RX_ER`=1 for one cycle, `receiving`=0. Then moves to RX_K.
  - TRI_RRI: `RX_DV`=0, `RX_ER`=0, `RXD`=0x00, `receiving`=0. /R/ stays. /K/ with rx_even=1 → RX_K. Anything else → WAIT_FOR_K.

## Timing
- `mr_main_reset`=1 takes effect at the next rising edge. It sets: state LINK_FAILED, RD−, `RXD`=0x00, `RX_DV`=0, `RX_ER`=0, `receiving`=0. It overrides any in-progress frame, and no error pulse is generated for an aborted frame.
- All outputs are registered.
- Latency: a group indicated in cycle n is reflected on the outputs in cycle n+1.
- `RX_DV` falls in the cycle after /T/ is indicated.
- One-cycle `RX_ER` pulses are one `Clk` period wide.
- Loss of sync and a valid group in the same cycle: loss of sync wins.

## Configuration
- `PCS_RX_DISPARITY_CHECK_EN` defined:
  - A group is valid only if it belongs to the column for the current RD; a wrong-column group is treated as INVALID.
  - The RD update for an INVALID group uses the same ones-count rule as for accepted groups.
- Undefined: either disparity column is accepted, and RD is still tracked but never used for validity.

## Test plan
- Reset plus idle: assert reset 2 cycles, then `code_sync_status`=1 with alternating /K/ (even) and D16.2 → FSM in IDLE_D; `RXD`=0x00, `RX_DV`=0, `RX_ER`=0 throughout.
- Frame: idle, /S/, then D groups for 0x01, 0x03, 0x9A, 0xB5, 0x42, then /T/ /R/ /K/ → `RXD`=0x55, 0x01, 0x03, 0x9A, 0xB5, 0x42 on consecutive indicated cycles, each one cycle after its group, with `RX_DV`=1; `RX_DV`=0 and `receiving`=0 the cycle after /T/; FSM returns to RX_K.
- Invalid mid-frame: 0x3FF after 0x9A → that output cycle has `RX_ER`=1, `RX_DV`=1, `RXD`=0x9A; the next valid D 0xB5 clears `RX_ER`.
- Early end and sync loss:
  - /K/ in place of /T/ → one cycle `RX_DV`=0, `RX_ER`=1, then normal idle.
  - In a separate frame, drop `code_sync_status` → one `RX_ER` pulse, then all outputs 0 until resync.
- Reset mid-frame: assert reset after 0x03 → next cycle all outputs 0, with no `RX_ER` pulse.
- Disparity (run with and without `PCS_RX_DISPARITY_CHECK_EN`): feed D3.0 in its RD+ form while RD=RD− → with the macro, `RX_ER`=1; without it, `RXD`=0x03 and `RX_ER`=0.

Source files
------------

// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive: 8b/10b decode of the SUDI stream and GMII receive FSM.
// Define PCS_RX_DISPARITY_CHECK_EN to reject code groups from the wrong disparity column.
module pcs_receive (
   input  logic        Clk,
   input  logic        mr_main_reset,
   input  logic        code_sync_status,
   input  logic        SUDI_indicate,
   input  logic [10:0] SUDI,
   output logic [7:0]  RXD,
   output logic        RX_DV,
   output logic        RX_ER,
   output logic        receiving
);

   localparam int unsigned CG_W  = 10;
   localparam int unsigned OCT_W = 8;

   localparam logic [2:0] LINK_FAILED     = 3'd0;
   localparam logic [2:0] WAIT_FOR_K      = 3'd1;
   localparam logic [2:0] RX_K            = 3'd2;
   localparam logic [2:0] IDLE_D          = 3'd3;
   localparam logic [2:0] START_OF_PACKET = 3'd4;
   localparam logic [2:0] RECEIVE         = 3'd5;
   localparam logic [2:0] EARLY_END       = 3'd6;
   localparam logic [2:0] TRI_RRI         = 3'd7;

   // Special groups, RD- and RD+ forms
   localparam logic [CG_W-1:0] K28_5_N = 10'b0011111010;
   localparam logic [CG_W-1:0] K28_5_P = 10'b1100000101;
   localparam logic [CG_W-1:0] K27_7_N = 10'b1101101000;
   localparam logic [CG_W-1:0] K27_7_P = 10'b0010010111;
   localparam logic [CG_W-1:0] K29_7_N = 10'b1011101000;
   localparam logic [CG_W-1:0] K29_7_P = 10'b0100010111;
   localparam logic [CG_W-1:0] K23_7_N = 10'b1110101000;
   localparam logic [CG_W-1:0] K23_7_P = 10'b0001010111;

   // abcdei sub-block -> {known, EDCBA}
   function automatic logic [5:0] dec6(input logic [5:0] c);
      logic [5:0] r;
      r = 6'b0;
      case (c)
         6'b100111, 6'b011000: r = {1'b1, 5'd0};
         6'b011101, 6'b100010: r = {1'b1, 5'd1};
         6'b101101, 6'b010010: r = {1'b1, 5'd2};
         6'b110001:            r = {1'b1, 5'd3};
         6'b110101, 6'b001010: r = {1'b1, 5'd4};
         6'b101001:            r = {1'b1, 5'd5};
         6'b011001:            r = {1'b1, 5'd6};
         6'b111000, 6'b000111: r = {1'b1, 5'd7};
         6'b111001, 6'b000110: r = {1'b1, 5'd8};
         6'b100101:            r = {1'b1, 5'd9};
         6'b010101:            r = {1'b1, 5'd10};
         6'b110100:            r = {1'b1, 5'd11};
         6'b001101:            r = {1'b1, 5'd12};
         6'b101100:            r = {1'b1, 5'd13};
         6'b011100:            r = {1'b1, 5'd14};
         6'b010111, 6'b101000: r = {1'b1, 5'd15};
         6'b011011, 6'b100100: r = {1'b1, 5'd16};
         6'b100011:            r = {1'b1, 5'd17};
         6'b010011:            r = {1'b1, 5'd18};
         6'b110010:            r = {1'b1, 5'd19};
         6'b001011:            r = {1'b1, 5'd20};
         6'b101010:            r = {1'b1, 5'd21};
         6'b011010:            r = {1'b1, 5'd22};
         6'b111010, 6'b000101: r = {1'b1, 5'd23};
         6'b110011, 6'b001100: r = {1'b1, 5'd24};
         6'b100110:            r = {1'b1, 5'd25};
         6'b010110:            r = {1'b1, 5'd26};
         6'b110110, 6'b001001: r = {1'b1, 5'd27};
         6'b001110:            r = {1'b1, 5'd28};
         6'b101110, 6'b010001: r = {1'b1, 5'd29};
         6'b011110, 6'b100001: r = {1'b1, 5'd30};
         6'b101011, 6'b010100: r = {1'b1, 5'd31};
         default:              r = 6'b0;
      endcase
      return r;
   endfunction

   // fghj sub-block -> {known, HGF}
   function automatic logic [3:0] dec4(input logic [3:0] c);
      logic [3:0] r;
      r = 4'b0;
      case (c)
         4'b1011, 4'b0100:                   r = {1'b1, 3'd0};
         4'b1001:                            r = {1'b1, 3'd1};
         4'b0101:                            r = {1'b1, 3'd2};
         4'b1100, 4'b0011:                   r = {1'b1, 3'd3};
         4'b1101, 4'b0010:                   r = {1'b1, 3'd4};
         4'b1010:                            r = {1'b1, 3'd5};
         4'b0110:                            r = {1'b1, 3'd6};
         4'b1110, 4'b0001, 4'b0111, 4'b1000: r = {1'b1, 3'd7};
         default:                            r = 4'b0;
      endcase
      return r;
   endfunction

   // True when cg is a legal Dx.y in the column selected by rd_in (1 = RD+)
   function automatic logic d_col(input logic [CG_W-1:0] cg, input logic rd_in);
      logic [5:0] d6;
      logic [3:0] d4;
      logic       ok6, ok4, rd_mid, alt7;
      int         n6, n4;
      d6 = dec6(cg[9:4]);
      d4 = dec4(cg[3:0]);
      n6 = $countones(cg[9:4]);
      n4 = $countones(cg[3:0]);
      if (n6 == 4)                    ok6 = ~rd_in;
      else if (n6 == 2)               ok6 = rd_in;
      else if (cg[9:4] == 6'b111000)  ok6 = ~rd_in;
      else if (cg[9:4] == 6'b000111)  ok6 = rd_in;
      else                            ok6 = 1'b1;
      rd_mid = (n6 == 4) ? 1'b1 : ((n6 == 2) ? 1'b0 : rd_in);
      if (n4 == 3)                    ok4 = ~rd_mid;
      else if (n4 == 1)               ok4 = rd_mid;
      else if (cg[3:0] == 4'b1100)    ok4 = ~rd_mid;
      else if (cg[3:0] == 4'b0011)    ok4 = rd_mid;
      else                            ok4 = 1'b1;
      // Dx.A7 replaces Dx.P7 only where P7 would form a run of five
      alt7 = rd_mid ? (d6[4:0] == 5'd11 || d6[4:0] == 5'd13 || d6[4:0] == 5'd14)
                    : (d6[4:0] == 5'd17 || d6[4:0] == 5'd18 || d6[4:0] == 5'd20);
      if (cg[3:0] == 4'b0111 || cg[3:0] == 4'b1000)      ok4 = ok4 & alt7;
      else if (cg[3:0] == 4'b1110 || cg[3:0] == 4'b0001) ok4 = ok4 & ~alt7;
      return d6[5] & d4[3] & ok6 & ok4;
   endfunction

   function automatic logic special(input logic [CG_W-1:0] cg, input logic [CG_W-1:0] kn,
                                    input logic [CG_W-1:0] kp, input logic rd_in);
`ifdef PCS_RX_DISPARITY_CHECK_EN
      return cg == (rd_in ? kp : kn);
`else
      return (rd_in | ~rd_in) & ((cg == kn) || (cg == kp));
`endif
   endfunction

   function automatic logic rd_after(input logic [CG_W-1:0] cg, input logic rd_in);
      int n;
      n = $countones(cg);
      return (n == 6) ? 1'b1 : ((n == 4) ? 1'b0 : rd_in);
   endfunction

   logic [2:0]       state, state_nx;
   logic             rd, rd_nx;
   logic [OCT_W-1:0] rxd_nx;
   logic             rx_dv_nx, rx_er_nx, receiving_nx;

   logic [CG_W-1:0]  cg;
   logic             rx_even;
   logic [5:0]       d6_w;
   logic [3:0]       d4_w;
   logic [OCT_W-1:0] oct_c;
   logic             d_valid, is_k, is_s, is_t, is_r;

   // Code-group classification for the current SUDI
   always_comb begin
      cg      = SUDI[CG_W-1:0];
      rx_even = SUDI[CG_W];
      d6_w    = dec6(cg[9:4]);
      d4_w    = dec4(cg[3:0]);
      oct_c   = {d4_w[2:0], d6_w[4:0]};
`ifdef PCS_RX_DISPARITY_CHECK_EN
      d_valid = d_col(cg, rd);
`else
      d_valid = d_col(cg, 1'b0) | d_col(cg, 1'b1);
`endif
      is_k    = special(cg, K28_5_N, K28_5_P, rd);
      is_s    = special(cg, K27_7_N, K27_7_P, rd);
      is_t    = special(cg, K29_7_N, K29_7_P, rd);
      is_r    = special(cg, K23_7_N, K23_7_P, rd);
   end

   always_ff @(posedge Clk) begin
      if (mr_main_reset) begin
         state     <= LINK_FAILED;
         rd        <= 1'b0;
         RXD       <= '0;
         RX_DV     <= 1'b0;
         RX_ER     <= 1'b0;
         receiving <= 1'b0;
      end else begin
         state     <= state_nx;
         rd        <= rd_nx;
         RXD       <= rxd_nx;
         RX_DV     <= rx_dv_nx;
         RX_ER     <= rx_er_nx;
         receiving <= receiving_nx;
      end
   end

   // Next state and next registered outputs
   always_comb begin
      state_nx     = state;
      rxd_nx       = RXD;
      rx_dv_nx     = RX_DV;
      rx_er_nx     = RX_ER;
      receiving_nx = receiving;
      rd_nx        = SUDI_indicate ? rd_after(cg, rd) : rd;

      if (!code_sync_status) begin
         state_nx     = LINK_FAILED;
         rxd_nx       = '0;
         rx_dv_nx     = 1'b0;
         receiving_nx = 1'b0;
         rx_er_nx     = (state == START_OF_PACKET) || (state == RECEIVE);
      end else if (!SUDI_indicate) begin
         // Error pulses last one clock even while the stream stalls
         if (state == EARLY_END || state == LINK_FAILED) rx_er_nx = 1'b0;
      end else begin
         rxd_nx       = '0;
         rx_dv_nx     = 1'b0;
         rx_er_nx     = 1'b0;
         receiving_nx = 1'b0;
         case (state)
            LINK_FAILED: state_nx = WAIT_FOR_K;
            WAIT_FOR_K:  if (is_k && rx_even) state_nx = RX_K;
            RX_K:        state_nx = d_valid ? IDLE_D : WAIT_FOR_K;
            IDLE_D: begin
               if (is_k) begin
                  state_nx = RX_K;
               end else if (is_s) begin
                  state_nx     = START_OF_PACKET;
                  rxd_nx       = 8'h55;
                  rx_dv_nx     = 1'b1;
                  receiving_nx = 1'b1;
               end else begin
                  state_nx = WAIT_FOR_K;
               end
            end
            START_OF_PACKET, RECEIVE: begin
               if (is_t) begin
                  state_nx = TRI_RRI;
               end else if (is_k) begin
                  state_nx = EARLY_END;
                  rx_er_nx = 1'b1;
               end else begin
                  state_nx     = RECEIVE;
                  rx_dv_nx     = 1'b1;
                  receiving_nx = 1'b1;
                  if (d_valid) begin
                     rxd_nx = oct_c;
                  end else begin
                     rxd_nx   = RXD;
                     rx_er_nx = 1'b1;
                  end
               end
            end
            EARLY_END: state_nx = RX_K;
            TRI_RRI: begin
               if (is_r)                 state_nx = TRI_RRI;
               else if (is_k && rx_even) state_nx = RX_K;
               else                      state_nx = WAIT_FOR_K;
            end
            default: state_nx = LINK_FAILED;
         endcase
      end
   end

endmodule
